// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle CPU boot path: instruction width and loader FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int INSTR_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } ld_state_e;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream MSB-first into 32-bit instruction words.
// Latency: word_o/word_full_o valid the cycle after the 4th byte is shifted in.
// Backpressure: none; shifts exactly when shift_i is high.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : synchronous clear (start of a new load), wins over shift_i
//   shift_i/byte_i: shift one byte into the low end of the word
//   word_o        : assembled word
//   last_byte_o   : next shifted byte completes a word
//   word_full_o   : a complete word is held (cleared by the next shift)
module word_assembler
  import cpu_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   shift_i,
  input  logic [7:0]             byte_i,
  output logic [INSTR_WIDTH-1:0] word_o,
  output logic                   last_byte_o,
  output logic                   word_full_o
);

  logic [INSTR_WIDTH-1:0] word_q;
  logic [1:0]             cnt_q;
  logic                   full_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (clear_i) begin
      word_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (shift_i) begin
      word_q <= {word_q[INSTR_WIDTH-9:0], byte_i};
      cnt_q  <= cnt_q + 2'd1;  // wraps to 0 after the 4th byte
      full_q <= (cnt_q == 2'd3);
    end
  end

  assign word_o      = word_q;
  assign last_byte_o = (cnt_q == 2'd3);
  assign word_full_o = full_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: holds the CPU in reset, writes a framed, XOR-checksummed byte stream into imem.
// Latency: MemWe one cycle after a word's 4th byte; Done/Error one cycle after the checksum byte.
// Backpressure: ByteReady high only in HDR_HI/HDR_LO/DATA/CHK, decoded from state alone.
//   Clock, Reset_n     : clock shared with CPU, async active-low reset
//   Start              : begin a load (honoured only in IDLE/DONE/ERR)
//   ByteValid/ByteData : stream input; ByteReady is the handshake back
//   MemWe/MemAddr/MemWData : instruction-memory write port
//   CpuHold/Done/Error : CPU reset hold and load status
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Start,
  input  logic                   ByteValid,
  input  logic [7:0]             ByteData,
  output logic                   ByteReady,
  output logic                   MemWe,
  output logic [ADDR_WIDTH-1:0]  MemAddr,
  output logic [INSTR_WIDTH-1:0] MemWData,
  output logic                   CpuHold,
  output logic                   Done,
  output logic                   Error
);

  localparam int          DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [16:0] DEPTH_C = 17'(DEPTH);

  ld_state_e             state_q, state_d;
  // One extra bit so a load of exactly DEPTH words ends without wrapping.
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [15:0]           count_q, count_d;
  logic [7:0]            chk_q, chk_d;

  logic                   xfer;
  logic                   start_ok;
  logic                   asm_shift;
  logic                   asm_clear;
  logic [INSTR_WIDTH-1:0] asm_word;
  logic                   asm_last;
  logic                   asm_full;
  logic [16:0]            hdr_count;
  logic [16:0]            idx_inc;

  word_assembler u_word_assembler (
    .clk_i      (Clock),
    .rst_ni     (Reset_n),
    .clear_i    (asm_clear),
    .shift_i    (asm_shift),
    .byte_i     (ByteData),
    .word_o     (asm_word),
    .last_byte_o(asm_last),
    .word_full_o(asm_full)
  );

  assign xfer      = ByteValid && ByteReady;
  assign start_ok  = Start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  // Full count as it will be once the low byte lands, for the range check.
  assign hdr_count = {1'b0, count_q[15:8], ByteData};
  assign idx_inc   = 17'(idx_q) + 17'd1;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      count_q <= '0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      chk_q   <= chk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    chk_d     = chk_q;
    asm_shift = 1'b0;
    asm_clear = 1'b0;
    if (start_ok) begin
      state_d   = ST_HDR_HI;
      idx_d     = '0;
      count_d   = '0;
      chk_d     = '0;
      asm_clear = 1'b1;
    end else begin
      case (state_q)
        ST_HDR_HI: if (xfer) begin
          count_d = {ByteData, count_q[7:0]};
          state_d = ST_HDR_LO;
        end
        ST_HDR_LO: if (xfer) begin
          count_d = {count_q[15:8], ByteData};
          state_d = (hdr_count == 17'd0 || hdr_count > DEPTH_C) ? ST_ERR : ST_DATA;
        end
        ST_DATA: if (xfer) begin
          asm_shift = 1'b1;
          chk_d     = chk_q ^ ByteData;
          if (asm_last) state_d = ST_WRITE;
        end
        ST_WRITE: begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_inc == {1'b0, count_q}) ? ST_CHK : ST_DATA;
        end
        ST_CHK: if (xfer) begin
          state_d = (ByteData == chk_q) ? ST_DONE : ST_ERR;
        end
        default: ;
      endcase
    end
  end

  assign ByteReady = state_q inside {ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_CHK};
  // WRITE is only ever entered with a full word; the flag keeps the strobe tied to real data.
  assign MemWe     = (state_q == ST_WRITE) && asm_full;
  assign MemAddr   = idx_q[ADDR_WIDTH-1:0];
  assign MemWData  = asm_word;
  assign CpuHold   = (state_q != ST_DONE);
  assign Done      = (state_q == ST_DONE);
  assign Error     = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with ADDR_WIDTH=2 (DEPTH=4) so count boundaries are reachable.
// Inputs are driven on the falling edge; memory writes are logged on the falling edge.
module tb_imem_loader;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic        ByteValid;
  logic [7:0]  ByteData;
  logic        ByteReady;
  logic        MemWe;
  logic [1:0]  MemAddr;
  logic [31:0] MemWData;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  int          checks = 0;
  int          errors = 0;
  int          xfers  = 0;
  logic [31:0] wbuf [8];
  logic [1:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  imem_loader #(.ADDR_WIDTH(2)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .ByteValid(ByteValid),
    .ByteData (ByteData),
    .ByteReady(ByteReady),
    .MemWe    (MemWe),
    .MemAddr  (MemAddr),
    .MemWData (MemWData),
    .CpuHold  (CpuHold),
    .Done     (Done),
    .Error    (Error)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (MemWe) begin
      wr_addr_q.push_back(MemAddr);
      wr_data_q.push_back(MemWData);
    end
  end

  always @(posedge Clock) begin
    if (ByteValid && ByteReady) xfers++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_chk(input int n);
    logic [7:0] c;
    logic [31:0] w;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = wbuf[i];
      c = c ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    return c;
  endfunction

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    xfers = 0;
  endtask

  // Called and returns on a falling edge; Start is high across exactly one rising edge.
  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Optional random idle gap, then hold the byte until it is taken on a rising edge.
  task automatic send_byte(input logic [7:0] b, input int max_stall);
    int n;
    int guard;
    n = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
    repeat (n) @(negedge Clock);
    ByteData  = b;
    ByteValid = 1'b1;
    guard = 0;
    while (!ByteReady && guard < 50) begin
      @(negedge Clock);
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL byte_timeout got ByteReady=%0b want 1 within 50 cycles", ByteReady);
    end
    @(negedge Clock);
    ByteValid = 1'b0;
  endtask

  task automatic send_hdr(input int n);
    logic [15:0] c;
    c = 16'(n);
    send_byte(c[15:8], 0);
    send_byte(c[7:0], 0);
  endtask

  // Sends data bytes [first, first+num) of the wbuf stream, MSB of each word first.
  task automatic send_data(input int first, input int num, input int max_stall);
    logic [31:0] w;
    for (int k = first; k < first + num; k++) begin
      w = wbuf[k / 4];
      send_byte(w[31 - 8 * (k % 4) -: 8], max_stall);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Start = 1'b0; ByteValid = 1'b0; ByteData = 8'h00;
    @(negedge Clock);
    checks++; if (ByteReady !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ByteReady); end
    checks++; if (MemWe !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", MemWe); end
    checks++; if (MemAddr !== 2'd0) begin errors++; $display("FAIL rst_addr got %h want 0", MemAddr); end
    checks++; if (MemWData !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", MemWData); end
    checks++; if (CpuHold !== 1'b1) begin errors++; $display("FAIL rst_hold got %b want 1", CpuHold); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", Done); end
    checks++; if (Error !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", Error); end
    Reset_n = 1'b1;
    repeat (2) @(negedge Clock);
    checks++; if (ByteReady !== 1'b0 || CpuHold !== 1'b1) begin
      errors++; $display("FAIL idle_outputs got ready=%b hold=%b want 0 1", ByteReady, CpuHold);
    end
  endtask

  task automatic test_nominal();
    wbuf[0] = 32'h2008_0005;
    wbuf[1] = 32'h8C09_0004;
    clear_log();
    pulse_start();
    checks++; if (ByteReady !== 1'b1) begin errors++; $display("FAIL nom_hdr_ready got %b want 1", ByteReady); end
    send_hdr(2);
    send_data(0, 4, 0);
    // Fourth byte taken on the previous rising edge: write strobe now, stream paused.
    checks++; if (MemWe !== 1'b1 || MemAddr !== 2'd0 || MemWData !== 32'h2008_0005) begin
      errors++; $display("FAIL nom_write_latency got we=%b addr=%0d data=%h want 1 0 20080005", MemWe, MemAddr, MemWData);
    end
    checks++; if (ByteReady !== 1'b0) begin errors++; $display("FAIL nom_write_ready got %b want 0", ByteReady); end
    send_data(4, 4, 0);
    // XOR of 20 08 00 05 8C 09 00 04 is 0xAC.
    send_byte(8'hAC, 0);
    checks++; if (Done !== 1'b1 || CpuHold !== 1'b0 || Error !== 1'b0) begin
      errors++; $display("FAIL nom_status got done=%b hold=%b err=%b want 1 0 0", Done, CpuHold, Error);
    end
    checks++; if (wr_addr_q.size() != 2) begin errors++; $display("FAIL nom_wr_count got %0d want 2", wr_addr_q.size()); end
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== 2'(i) || wr_data_q[i] !== wbuf[i]) begin
        errors++; $display("FAIL nom_wr%0d got %0d:%h want %0d:%h", i, wr_addr_q[i], wr_data_q[i], i, wbuf[i]);
      end
    end
    checks++; if (xfers != 11) begin errors++; $display("FAIL nom_xfers got %0d want 11", xfers); end
  endtask

  task automatic test_bad_chk();
    clear_log();
    pulse_start();
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL bad_restart_done got %b want 0", Done); end
    send_hdr(2);
    send_data(0, 8, 0);
    send_byte(8'h00, 0);
    checks++; if (Error !== 1'b1 || Done !== 1'b0 || CpuHold !== 1'b1) begin
      errors++; $display("FAIL bad_status got err=%b done=%b hold=%b want 1 0 1", Error, Done, CpuHold);
    end
    checks++; if (wr_addr_q.size() != 2) begin errors++; $display("FAIL bad_wr_count got %0d want 2", wr_addr_q.size()); end
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== 2'(i) || wr_data_q[i] !== wbuf[i]) begin
        errors++; $display("FAIL bad_wr%0d got %0d:%h want %0d:%h", i, wr_addr_q[i], wr_data_q[i], i, wbuf[i]);
      end
    end
    repeat (3) @(negedge Clock);
    checks++; if (Error !== 1'b1) begin errors++; $display("FAIL bad_sticky got %b want 1", Error); end
    clear_log();
    pulse_start();
    checks++; if (Error !== 1'b0) begin errors++; $display("FAIL bad_restart_err got %b want 0", Error); end
    send_hdr(2);
    send_data(0, 8, 0);
    send_byte(8'hAC, 0);
    checks++; if (Done !== 1'b1 || Error !== 1'b0 || CpuHold !== 1'b0) begin
      errors++; $display("FAIL bad_reload got done=%b err=%b hold=%b want 1 0 0", Done, Error, CpuHold);
    end
  endtask

  task automatic test_count_bounds();
    clear_log();
    pulse_start();
    send_hdr(0);
    checks++; if (Error !== 1'b1 || ByteReady !== 1'b0) begin
      errors++; $display("FAIL n0_status got err=%b ready=%b want 1 0", Error, ByteReady);
    end
    repeat (2) @(negedge Clock);
    checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL n0_writes got %0d want 0", wr_addr_q.size()); end

    clear_log();
    pulse_start();
    send_hdr(5);
    checks++; if (Error !== 1'b1 || Done !== 1'b0) begin
      errors++; $display("FAIL n5_status got err=%b done=%b want 1 0", Error, Done);
    end
    repeat (2) @(negedge Clock);
    checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL n5_writes got %0d want 0", wr_addr_q.size()); end

    wbuf[0] = 32'h0123_4567;
    wbuf[1] = 32'h89AB_CDEF;
    wbuf[2] = 32'hDEAD_BEEF;
    wbuf[3] = 32'h00FF_00FF;
    clear_log();
    pulse_start();
    send_hdr(4);
    send_data(0, 16, 0);
    send_byte(model_chk(4), 0);
    checks++; if (Done !== 1'b1 || Error !== 1'b0) begin
      errors++; $display("FAIL n4_status got done=%b err=%b want 1 0", Done, Error);
    end
    checks++; if (wr_addr_q.size() != 4) begin errors++; $display("FAIL n4_wr_count got %0d want 4", wr_addr_q.size()); end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== 2'(i) || wr_data_q[i] !== wbuf[i]) begin
        errors++; $display("FAIL n4_wr%0d got %0d:%h want %0d:%h", i, wr_addr_q[i], wr_data_q[i], i, wbuf[i]);
      end
    end
  endtask

  task automatic test_stalls();
    wbuf[0] = 32'hA5A5_0001;
    wbuf[1] = 32'h1234_5678;
    wbuf[2] = 32'hFFFF_0000;
    clear_log();
    pulse_start();
    send_byte(8'h00, 2);
    send_byte(8'h03, 2);
    send_data(0, 12, 2);
    send_byte(model_chk(3), 2);
    checks++; if (Done !== 1'b1 || CpuHold !== 1'b0) begin
      errors++; $display("FAIL stall_status got done=%b hold=%b want 1 0", Done, CpuHold);
    end
    checks++; if (xfers != 15) begin errors++; $display("FAIL stall_xfers got %0d want 15", xfers); end
    checks++; if (wr_addr_q.size() != 3) begin errors++; $display("FAIL stall_wr_count got %0d want 3", wr_addr_q.size()); end
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== 2'(i) || wr_data_q[i] !== wbuf[i]) begin
        errors++; $display("FAIL stall_wr%0d got %0d:%h want %0d:%h", i, wr_addr_q[i], wr_data_q[i], i, wbuf[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send_hdr(3);
    send_data(0, 6, 0);
    checks++; if (MemAddr !== 2'd1 || ByteReady !== 1'b1) begin
      errors++; $display("FAIL mid_pre got addr=%0d ready=%b want 1 1", MemAddr, ByteReady);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (ByteReady !== 1'b0 || MemWe !== 1'b0 || MemAddr !== 2'd0 || MemWData !== 32'h0) begin
      errors++; $display("FAIL mid_rst_port got ready=%b we=%b addr=%0d data=%h want 0 0 0 0", ByteReady, MemWe, MemAddr, MemWData);
    end
    checks++; if (CpuHold !== 1'b1 || Done !== 1'b0 || Error !== 1'b0) begin
      errors++; $display("FAIL mid_rst_status got hold=%b done=%b err=%b want 1 0 0", CpuHold, Done, Error);
    end
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    clear_log();
    pulse_start();
    send_hdr(3);
    send_data(0, 12, 0);
    send_byte(model_chk(3), 0);
    checks++; if (Done !== 1'b1 || wr_addr_q.size() != 3) begin
      errors++; $display("FAIL mid_reload got done=%b writes=%0d want 1 3", Done, wr_addr_q.size());
    end
    for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== 2'(i) || wr_data_q[i] !== wbuf[i]) begin
        errors++; $display("FAIL mid_wr%0d got %0d:%h want %0d:%h", i, wr_addr_q[i], wr_data_q[i], i, wbuf[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    wbuf[0] = 32'h2008_0005;
    wbuf[1] = 32'h8C09_0004;
    clear_log();
    pulse_start();
    send_hdr(2);
    send_data(0, 3, 0);
    pulse_start();
    checks++; if (ByteReady !== 1'b1 || Done !== 1'b0 || Error !== 1'b0) begin
      errors++; $display("FAIL ign_data got ready=%b done=%b err=%b want 1 0 0", ByteReady, Done, Error);
    end
    send_data(3, 5, 0);
    // Start held across the edge that enters DONE must not restart the load.
    Start = 1'b1;
    send_byte(8'hAC, 0);
    Start = 1'b0;
    checks++; if (Done !== 1'b1 || CpuHold !== 1'b0) begin
      errors++; $display("FAIL ign_done got done=%b hold=%b want 1 0", Done, CpuHold);
    end
    checks++; if (wr_addr_q.size() != 2) begin errors++; $display("FAIL ign_wr_count got %0d want 2", wr_addr_q.size()); end
    for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] !== 2'(i) || wr_data_q[i] !== wbuf[i]) begin
        errors++; $display("FAIL ign_wr%0d got %0d:%h want %0d:%h", i, wr_addr_q[i], wr_data_q[i], i, wbuf[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_chk();
    test_count_bounds();
    test_stalls();
    test_reset_mid();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
